// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Lookup is combinational. Execute-stage updates and the perf counters commit on the rising edge.
module btb_predictor #(
  parameter int IDX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        btb_found,
  output logic        predict_result,
  output logic [31:0] predict_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken,
  input  logic        upd_uncond,
  input  logic        upd_mispredict,
  output logic [31:0] upd_count,
  output logic [31:0] mispredict_count
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = 30 - IDX_BITS;

  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] uncond_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [1:0]         cnt_q    [ENTRIES];
  logic [31:0]        upd_count_q, upd_count_d;
  logic [31:0]        misp_count_q, misp_count_d;

  logic [IDX_BITS-1:0] if_idx, upd_idx;
  logic [TAG_W-1:0]    if_tag, upd_tag;
  logic                upd_hit, entry_we;
  logic [1:0]          cnt_d;
  logic [31:0]         target_d;
  logic                uncond_d;

  assign if_idx  = if_pc[IDX_BITS+1:2];
  assign if_tag  = if_pc[31:IDX_BITS+2];
  assign upd_idx = upd_pc[IDX_BITS+1:2];
  assign upd_tag = upd_pc[31:IDX_BITS+2];

  // The rst gate holds the lookup outputs low for the whole reset window.
  // This does not depend on how quickly the entry state clears.
  always_comb begin
    btb_found      = !rst && valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    predict_result = btb_found && (uncond_q[if_idx] || cnt_q[if_idx][1]);
    predict_target = btb_found ? target_q[if_idx] : 32'h0;
  end

  always_comb begin
    upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    entry_we = 1'b0;
    cnt_d    = cnt_q[upd_idx];
    target_d = target_q[upd_idx];
    uncond_d = uncond_q[upd_idx];
    if (upd_valid) begin
      if (upd_hit) begin
        entry_we = 1'b1;
        if (upd_taken) begin
          cnt_d    = (cnt_q[upd_idx] == 2'd3) ? 2'd3 : cnt_q[upd_idx] + 2'd1;
          target_d = upd_target;
          uncond_d = upd_uncond;
        end else begin
          cnt_d = (cnt_q[upd_idx] == 2'd0) ? 2'd0 : cnt_q[upd_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        // A taken miss allocates and evicts whatever alias held the slot.
        entry_we = 1'b1;
        cnt_d    = 2'b10;
        target_d = upd_target;
        uncond_d = upd_uncond;
      end
    end
  end

  assign upd_count_d  = upd_count_q + {31'd0, upd_valid};
  assign misp_count_d = misp_count_q + {31'd0, upd_valid & upd_mispredict};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= '0;
      uncond_q     <= '0;
      upd_count_q  <= 32'd0;
      misp_count_q <= 32'd0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= 32'd0;
        cnt_q[i]    <= 2'b01;
      end
    end else begin
      upd_count_q  <= upd_count_d;
      misp_count_q <= misp_count_d;
      if (entry_we) begin
        valid_q[upd_idx]  <= 1'b1;
        uncond_q[upd_idx] <= uncond_d;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= target_d;
        cnt_q[upd_idx]    <= cnt_d;
      end
    end
  end

  assign upd_count        = upd_count_q;
  assign mispredict_count = misp_count_q;

endmodule

// File: tb/tb_btb_predictor.sv
// Directed bench for btb_predictor. Expected lookup/counter values come from a small bench model.
// They are queued as a scoreboard and compared against the DUT outputs.
module tb_btb_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] if_pc = 32'h0;
  logic        btb_found, predict_result;
  logic [31:0] predict_target;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = 32'h0, upd_target = 32'h0;
  logic        upd_taken = 1'b0, upd_uncond = 1'b0, upd_mispredict = 1'b0;
  logic [31:0] upd_count, mispredict_count;

  typedef struct {
    logic        found;
    logic        pred;
    logic [31:0] target;
    logic [31:0] ucnt;
    logic [31:0] mcnt;
  } exp_t;

  exp_t  sb_q[$];
  string name_q[$];
  int    checks = 0;
  int    failures = 0;
  logic [31:0] exp_uc = 32'd0;
  logic [31:0] exp_mc = 32'd0;

  always #5 clk = ~clk;

  btb_predictor #(.IDX_BITS(4)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc),
    .btb_found(btb_found), .predict_result(predict_result), .predict_target(predict_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_taken(upd_taken), .upd_uncond(upd_uncond), .upd_mispredict(upd_mispredict),
    .upd_count(upd_count), .mispredict_count(mispredict_count)
  );

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push_exp(input string name, input logic f, input logic p, input logic [31:0] t);
    exp_t e;
    e.found = f; e.pred = p; e.target = t; e.ucnt = exp_uc; e.mcnt = exp_mc;
    sb_q.push_back(e);
    name_q.push_back(name);
  endtask

  task automatic pop_check();
    exp_t  e;
    string n;
    e = sb_q.pop_front();
    n = name_q.pop_front();
    cmp({n, "_found"}, {31'd0, btb_found}, {31'd0, e.found});
    cmp({n, "_pred"}, {31'd0, predict_result}, {31'd0, e.pred});
    cmp({n, "_target"}, predict_target, e.target);
    cmp({n, "_ucnt"}, upd_count, e.ucnt);
    cmp({n, "_mcnt"}, mispredict_count, e.mcnt);
    $display("txn %s: pc=%h found=%0b pred=%0b target=%h ucnt=%0d mcnt=%0d",
             n, if_pc, btb_found, predict_result, predict_target, upd_count, mispredict_count);
  endtask

  // Look up pc combinationally and compare against the expectation.
  task automatic look(input string name, input logic [31:0] pc, input logic f, input logic p,
                      input logic [31:0] t);
    if_pc = pc;
    push_exp(name, f, p, t);
    #1;
    pop_check();
  endtask

  // One accepted update. Called 1ns after a rising edge, it returns 1ns after the committing edge.
  task automatic do_upd(input logic [31:0] pc, input logic [31:0] tgt, input logic taken,
                        input logic uncond, input logic misp);
    upd_valid = 1'b1; upd_pc = pc; upd_target = tgt;
    upd_taken = taken; upd_uncond = uncond; upd_mispredict = misp;
    @(posedge clk);
    #1;
    upd_valid = 1'b0; upd_mispredict = 1'b0;
    exp_uc = exp_uc + 32'd1;
    if (misp) exp_mc = exp_mc + 32'd1;
  endtask

  initial begin
    // Reset state.
    if_pc = 32'h100;
    repeat (2) @(posedge clk);
    #1;
    look("reset", 32'h100, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;

    // Allocate, then a not-taken miss must not allocate.
    do_upd(32'h100, 32'h200, 1'b1, 1'b0, 1'b0);
    look("alloc", 32'h100, 1'b1, 1'b1, 32'h200);
    do_upd(32'h104, 32'h999, 1'b0, 1'b0, 1'b0);
    look("nt_miss", 32'h104, 1'b0, 1'b0, 32'h0);

    // Hysteresis and saturation.
    repeat (3) do_upd(32'h100, 32'h200, 1'b1, 1'b0, 1'b0);
    look("sat_hi", 32'h100, 1'b1, 1'b1, 32'h200);
    do_upd(32'h100, 32'h0, 1'b0, 1'b0, 1'b0);
    look("nt1", 32'h100, 1'b1, 1'b1, 32'h200);
    do_upd(32'h100, 32'h0, 1'b0, 1'b0, 1'b0);
    look("nt2", 32'h100, 1'b1, 1'b0, 32'h200);
    do_upd(32'h100, 32'h0, 1'b0, 1'b0, 1'b0);
    do_upd(32'h100, 32'h0, 1'b0, 1'b0, 1'b0);
    look("nt4", 32'h100, 1'b1, 1'b0, 32'h200);
    do_upd(32'h100, 32'h200, 1'b1, 1'b0, 1'b0);
    look("sat_lo", 32'h100, 1'b1, 1'b0, 32'h200);

    // Aliasing on index 0.
    look("alias_miss", 32'h140, 1'b0, 1'b0, 32'h0);
    do_upd(32'h140, 32'h300, 1'b1, 1'b0, 1'b0);
    look("alias_hit", 32'h140, 1'b1, 1'b1, 32'h300);
    look("alias_evict", 32'h100, 1'b0, 1'b0, 32'h0);

    // Unconditional jump keeps predicting taken. Mispredicts are counted.
    do_upd(32'h180, 32'h400, 1'b1, 1'b1, 1'b1);
    do_upd(32'h180, 32'h0, 1'b0, 1'b0, 1'b1);
    do_upd(32'h180, 32'h0, 1'b0, 1'b0, 1'b0);
    do_upd(32'h180, 32'h0, 1'b0, 1'b0, 1'b0);
    look("uncond", 32'h180, 1'b1, 1'b1, 32'h400);

    // Same-cycle lookup and update: pre-edge contents, then new entry.
    if_pc = 32'h100;
    upd_valid = 1'b1; upd_pc = 32'h100; upd_target = 32'h500;
    upd_taken = 1'b1; upd_uncond = 1'b0; upd_mispredict = 1'b0;
    #4;
    push_exp("same_cycle_pre", 1'b0, 1'b0, 32'h0);
    pop_check();
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    exp_uc = exp_uc + 32'd1;
    look("same_cycle_post", 32'h100, 1'b1, 1'b1, 32'h500);

    // Mid-cycle asynchronous reset. The update presented during reset is dropped.
    upd_valid = 1'b1; upd_pc = 32'h100; upd_target = 32'h700; upd_taken = 1'b1;
    rst = 1'b1;
    exp_uc = 32'd0; exp_mc = 32'd0;
    look("rst_async", 32'h100, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    rst = 1'b0;
    look("rst_cleared", 32'h100, 1'b0, 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
